// File: rtl/hamming_secded_link_if.sv
// Link-side bundle for the Hamming SECDED loopback link: word-in handshake,
// error injection, observed line bit, decoded word and error statistics.
interface hamming_secded_link_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              error;
    logic              line_bit;
    logic              line_valid;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_corrected;
    logic              out_uncorr;
    logic [CNT_W-1:0]  cnt_single;
    logic [CNT_W-1:0]  cnt_double;

    // Driver side: supplies words and the per-bit error pattern.
    modport master (
        output in_valid, in_data, error,
        input  in_ready, line_bit, line_valid, out_valid, out_data,
        input  out_corrected, out_uncorr, cnt_single, cnt_double
    );

    // Link side: the codec/serialiser itself.
    modport slave (
        input  in_valid, in_data, error,
        output in_ready, line_bit, line_valid, out_valid, out_data,
        output out_corrected, out_uncorr, cnt_single, cnt_double
    );
endinterface

// File: rtl/hamming_secded_link.sv
// Hamming SECDED serial link: encodes a parallel word, shifts the codeword out
// one bit per clock (optionally corrupted by the error input), collects the bits
// again, then corrects single errors / flags double errors and keeps statistics.
module hamming_secded_link #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_fast,
    input  logic                 rst_n,
    hamming_secded_link_if.slave link
);
    // Smallest r with 2^r >= DATA_W + r + 1.
    function automatic int calc_par_w(input int dw);
        int r;
        r = 32'sd1;
        while ((32'sd1 << r) < (dw + r + 32'sd1)) r = r + 32'sd1;
        return r;
    endfunction

    localparam int PAR_W = calc_par_w(DATA_W);
    localparam int N     = DATA_W + PAR_W;
    localparam int CW_W  = N + 1;
    localparam int IDX_W = $clog2(CW_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CW_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              corrected;
        logic              uncorr;
    } dec_t;

    // Parity positions are the powers of two in 1..N.
    function automatic logic is_pow2(input int v);
        return ((v & (v - 32'sd1)) == 32'sd0);
    endfunction

    // Codeword vector index i holds code position i+1; index N holds overall parity.
    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] data);
        logic [CW_W-1:0] cw;
        logic            p;
        int              d;
        cw = '0;
        d  = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if (!is_pow2(pos)) begin
                cw[pos-1] = data[d];
                d = d + 1;
            end
        end
        for (int k = 0; k < PAR_W; k++) begin
            p = 1'b0;
            for (int pos = 1; pos <= N; pos++) begin
                if (((pos >> k) & 32'sd1) != 32'sd0) p = p ^ cw[pos-1];
            end
            cw[(32'sd1 << k) - 1] = p;
        end
        cw[N] = ^cw[N-1:0];
        return cw;
    endfunction

    // Syndrome + overall parity classification, then data extraction.
    function automatic dec_t decode(input logic [CW_W-1:0] cw);
        dec_t             res;
        logic [PAR_W-1:0] syn;
        logic             ovr;
        logic [N-1:0]     pos_v;
        int               d;
        res   = '0;
        syn   = '0;
        for (int pos = 1; pos <= N; pos++) begin
            if (cw[pos-1]) syn = syn ^ PAR_W'(pos);
        end
        ovr   = ^cw;
        pos_v = cw[N-1:0];
        if (!ovr && (syn == '0)) begin
            res.corrected = 1'b0;
        end else if (ovr && (syn == '0)) begin
            // Only the overall parity bit was hit; data is intact.
            res.corrected = 1'b1;
        end else if (ovr && (int'(syn) <= N)) begin
            pos_v[int'(syn) - 1] = ~pos_v[int'(syn) - 1];
            res.corrected = 1'b1;
        end else begin
            // Even number of flips, or syndrome pointing past the codeword.
            res.uncorr = 1'b1;
        end
        d = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if (!is_pow2(pos)) begin
                res.data[d] = pos_v[pos-1];
                d = d + 1;
            end
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [CW_W-1:0]   tx_cw_q, tx_cw_d;
    logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
    logic [CW_W-1:0]   rx_q, rx_d;
    logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
    logic              in_ready_s;
    logic              accept_s;
    logic              line_valid_s;
    logic              line_bit_s;
    logic              word_done_s;
    dec_t              dec_s;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_corr_q;
    logic              out_uncorr_q;
    logic [CNT_W-1:0]  cnt_single_q;
    logic [CNT_W-1:0]  cnt_double_q;

    // Encoder FSM next state: ready in IDLE and on the last bit so words chain without a gap.
    always_comb begin
        state_d    = state_q;
        tx_cw_d    = tx_cw_q;
        tx_idx_d   = tx_idx_q;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                accept_s   = link.in_valid;
                if (accept_s) begin
                    state_d  = ST_SHIFT;
                    tx_cw_d  = encode(link.in_data);
                    tx_idx_d = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (tx_idx_q == LAST_IDX) begin
                    in_ready_s = 1'b1;
                    accept_s   = link.in_valid;
                    tx_idx_d   = '0;
                    if (accept_s) begin
                        tx_cw_d = encode(link.in_data);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tx_idx_d = tx_idx_q + IDX_W'(1'b1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_idx_d = '0;
            end
        endcase
    end

    // Line: the error input only matters while a codeword bit is on the wire.
    always_comb begin
        line_valid_s = (state_q == ST_SHIFT);
        if (line_valid_s) begin
            line_bit_s = tx_cw_q[tx_idx_q] ^ link.error;
        end else begin
            line_bit_s = 1'b0;
        end
    end

    // Receiver: collect line bits; the last one completes the word and is decoded directly.
    always_comb begin
        rx_d        = rx_q;
        rx_idx_d    = rx_idx_q;
        word_done_s = 1'b0;
        if (line_valid_s) begin
            rx_d[rx_idx_q] = line_bit_s;
            if (rx_idx_q == LAST_IDX) begin
                word_done_s = 1'b1;
                rx_idx_d    = '0;
            end else begin
                rx_idx_d    = rx_idx_q + IDX_W'(1'b1);
            end
        end else begin
            rx_idx_d = rx_idx_q;
        end
        dec_s = decode(rx_d);
    end

    // State, shift registers, registered decoder outputs and saturating statistics.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tx_cw_q      <= '0;
            tx_idx_q     <= '0;
            rx_q         <= '0;
            rx_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_cw_q     <= tx_cw_d;
            tx_idx_q    <= tx_idx_d;
            rx_q        <= rx_d;
            rx_idx_q    <= rx_idx_d;
            out_valid_q <= word_done_s;
            if (word_done_s) begin
                out_data_q   <= dec_s.data;
                out_corr_q   <= dec_s.corrected;
                out_uncorr_q <= dec_s.uncorr;
            end else begin
                out_corr_q   <= 1'b0;
                out_uncorr_q <= 1'b0;
            end
            if (word_done_s && dec_s.corrected && (cnt_single_q != {CNT_W{1'b1}})) begin
                cnt_single_q <= cnt_single_q + CNT_W'(1'b1);
            end
            if (word_done_s && dec_s.uncorr && (cnt_double_q != {CNT_W{1'b1}})) begin
                cnt_double_q <= cnt_double_q + CNT_W'(1'b1);
            end
        end
    end

    assign link.in_ready      = in_ready_s;
    assign link.line_valid    = line_valid_s;
    assign link.line_bit      = line_bit_s;
    assign link.out_valid     = out_valid_q;
    assign link.out_data      = out_data_q;
    assign link.out_corrected = out_corr_q;
    assign link.out_uncorr    = out_uncorr_q;
    assign link.cnt_single    = cnt_single_q;
    assign link.cnt_double    = cnt_double_q;

endmodule
